// File: rtl/jstepper_pkg.sv
// Shared definitions for the instruction step sequencer: state encodings and
// default geometry of the step ring and instruction counter.
package jstepper_pkg;

    localparam int NSTEPS_DEF = 6;
    localparam int CNTW_DEF   = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/jstepper_jedge.sv
// Registered falling-edge detector on ref_clk; also intended for the I/O clock.
// fall is high in the cycle after a 1->0 transition of sig has been seen.
module jedge (
    input  logic ref_clk,
    input  logic reset,
    input  logic sig,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign fall = sig_q & ~sig;

endmodule

// File: rtl/jstepper.sv
// Instruction step sequencer: one-hot step ring advanced on falling wclk,
// with halt/resume control, end-of-instruction pulse and instruction counter.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_RUN    | step ring rotates on each wclk fall, wraps at end of instr
//   ST_HALTED | step all-zero, icount frozen, waiting for resume + wclk fall
module jstepper
    import jstepper_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              wclk,
    input  logic              halt,
    input  logic              resume,
    output logic [NSTEPS-1:0] step,
    output logic              instr_done,
    output logic              halted,
    output logic [CNTW-1:0]   icount
);

    localparam logic [NSTEPS-1:0] STEP0 = NSTEPS'(1);

    state_t state;
    logic   halt_pend;
    logic   resume_pend;
    logic   fall;

    jedge u_jedge (
        .ref_clk (ref_clk),
        .reset   (reset),
        .sig     (wclk),
        .fall    (fall)
    );

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state       <= ST_RUN;
            step        <= STEP0;
            instr_done  <= 1'b0;
            halted      <= 1'b0;
            icount      <= '0;
            halt_pend   <= 1'b0;
            resume_pend <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    resume_pend <= 1'b0;
                    if (halt) begin
                        halt_pend <= 1'b1;
                    end
                    if (fall) begin
                        if (step[NSTEPS-1]) begin
                            icount     <= icount + CNTW'(1);
                            instr_done <= 1'b1;
                            // A halt arriving in the very last cycle still counts.
                            if (halt_pend || halt) begin
                                state     <= ST_HALTED;
                                step      <= '0;
                                halted    <= 1'b1;
                                halt_pend <= 1'b0;
                            end else begin
                                step <= STEP0;
                            end
                        end else begin
                            step <= {step[NSTEPS-2:0], 1'b0};
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        resume_pend <= 1'b1;
                    end
                    if (fall && (resume_pend || resume)) begin
                        state       <= ST_RUN;
                        step        <= STEP0;
                        halted      <= 1'b0;
                        resume_pend <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jstepper.sv
// Directed bench for jstepper: free run, halt, resume, simultaneous halt/resume,
// reset mid-instruction and while halted, and counter wrap with CNTW = 4.
module tb_jstepper;

    logic        ref_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        wclk    = 1'b0;
    logic        halt    = 1'b0;
    logic        resume  = 1'b0;

    logic [5:0]  step;
    logic        instr_done;
    logic        halted;
    logic [15:0] icount;

    logic [5:0]  step_w;
    logic        instr_done_w;
    logic        halted_w;
    logic [3:0]  icount_w;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    jstepper #(.NSTEPS(6), .CNTW(16)) dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .wclk       (wclk),
        .halt       (halt),
        .resume     (resume),
        .step       (step),
        .instr_done (instr_done),
        .halted     (halted),
        .icount     (icount)
    );

    jstepper #(.NSTEPS(6), .CNTW(4)) dut_w (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .wclk       (wclk),
        .halt       (1'b0),
        .resume     (1'b0),
        .step       (step_w),
        .instr_done (instr_done_w),
        .halted     (halted_w),
        .icount     (icount_w)
    );

    always #5 ref_clk = ~ref_clk;

    // Clock generator model: wclk toggles every ref_clk edge, 0 during reset.
    always @(posedge ref_clk) wclk <= reset ? 1'b0 : ~wclk;

    task automatic tick();
        @(posedge ref_clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [5:0] e_step, input logic e_done,
                             input logic e_halted, input logic [15:0] e_icount);
        chk({tag, ".step"},   32'(step),       32'(e_step));
        chk({tag, ".done"},   32'(instr_done), 32'(e_done));
        chk({tag, ".halted"}, 32'(halted),     32'(e_halted));
        chk({tag, ".icount"}, 32'(icount),     32'(e_icount));
    endtask

    initial begin
        logic [5:0] e_step;

        reset = 1'b1;
        tick();
        tick();
        chk_state("reset", 6'd1, 1'b0, 1'b0, 16'd0);
        chk("reset.wclk", 32'(wclk), 32'd0);
        reset = 1'b0;
        n = -1;

        // Free run: each step held 2 edges, wrap every 12 edges.
        for (int k = 0; k < 30; k++) begin
            tick();
            e_step = 6'd1 << ((n / 2) % 6);
            chk_state("freerun", e_step, (n > 0) && (n % 12 == 0), 1'b0, 16'(n / 12));
        end

        // One-cycle halt pulse during step[2].
        chk("halt.pre_step", 32'(step), 32'd4);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk_state("halt.e30", 6'd8, 1'b0, 1'b0, 16'd2);
        run_to(35);
        chk_state("halt.e35", 6'd32, 1'b0, 1'b0, 16'd2);
        tick();
        chk_state("halt.e36", 6'd0, 1'b1, 1'b1, 16'd3);
        tick();
        chk_state("halt.e37", 6'd0, 1'b0, 1'b1, 16'd3);
        halt = 1'b1;
        run_to(40);
        halt = 1'b0;
        chk_state("halt.e40", 6'd0, 1'b0, 1'b1, 16'd3);

        // One-cycle resume pulse while halted.
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk_state("resume.e41", 6'd0, 1'b0, 1'b1, 16'd3);
        tick();
        chk_state("resume.e42", 6'd1, 1'b0, 1'b0, 16'd3);
        run_to(44);
        chk("resume.e44.step", 32'(step), 32'd2);
        run_to(53);
        chk_state("resume.e53", 6'd32, 1'b0, 1'b0, 16'd3);
        tick();
        chk_state("resume.e54", 6'd1, 1'b1, 1'b0, 16'd4);
        tick();
        chk("resume.e55.done", 32'(instr_done), 32'd0);

        // Halt and resume held together from step[1].
        run_to(56);
        halt   = 1'b1;
        resume = 1'b1;
        run_to(65);
        chk_state("both.e65", 6'd32, 1'b0, 1'b0, 16'd4);
        tick();
        chk_state("both.e66", 6'd0, 1'b1, 1'b1, 16'd5);
        tick();
        halt   = 1'b0;
        resume = 1'b0;
        chk_state("both.e67", 6'd0, 1'b0, 1'b1, 16'd5);
        tick();
        chk_state("both.e68", 6'd1, 1'b0, 1'b0, 16'd5);

        // Pending halt, then reset during step[3].
        run_to(70);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        run_to(74);
        chk("rst_run.pre_step", 32'(step), 32'd8);
        reset = 1'b1;
        tick();
        chk_state("rst_run", 6'd1, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        n = -1;
        run_to(11);
        chk_state("rst_run.e11", 6'd32, 1'b0, 1'b0, 16'd0);
        tick();
        chk_state("rst_run.e12", 6'd1, 1'b1, 1'b0, 16'd1);

        // Reset while halted.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        run_to(24);
        chk_state("rst_halt.e24", 6'd0, 1'b1, 1'b1, 16'd2);
        tick();
        reset = 1'b1;
        tick();
        chk_state("rst_halt", 6'd1, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        n = -1;

        // 17 instructions: narrow counter wraps 15 -> 0 -> 1.
        run_to(180);
        chk("wrap.e180.icount", 32'(icount_w), 32'd15);
        chk("wrap.e180.step",   32'(step_w),   32'd1);
        chk("wrap.e180.done",   32'(instr_done_w), 32'd1);
        run_to(186);
        chk("wrap.e186.step",   32'(step_w),   32'd8);
        chk("wrap.e186.icount", 32'(icount_w), 32'd15);
        run_to(192);
        chk("wrap.e192.icount", 32'(icount_w), 32'd0);
        chk("wrap.e192.step",   32'(step_w),   32'd1);
        chk("wrap.e192.done",   32'(instr_done_w), 32'd1);
        tick();
        chk("wrap.e193.step",   32'(step_w),   32'd1);
        run_to(194);
        chk("wrap.e194.step",   32'(step_w),   32'd2);
        run_to(204);
        chk("wrap.e204.icount", 32'(icount_w), 32'd1);
        chk("wrap.e204.step",   32'(step_w),   32'd1);
        chk("wrap.e204.halted", 32'(halted_w), 32'd0);
        chk_state("wide.e204", 6'd1, 1'b1, 1'b0, 16'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
